fetch_pc_unit: RTL
==================

# fetch_pc_unit

Program-counter and fetch-redirect stage of the pipelined RV32I core. It holds the architectural fetch PC and drives the instruction-memory fetch handshake. It consumes the EX-stage branch decision (`branchtaken`) plus jump/target information, redirects fetch to the resolved target and emits the IF/ID and ID/EX flush pulses that squash wrong-path instructions. Misaligned targets are trapped, and taken redirects are counted for performance monitoring.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `TRAP_PC`, default 32'h0000_0100: redirect address used when a target is misaligned.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `stall_i` in 1: hazard-unit stall; holds the PC.
- `imem_ready_i` in 1: instruction memory accepts the presented fetch.
- `ex_branch_valid_i` in 1: EX holds a conditional branch.
- `branchtaken_i` in 1: branch outcome from the branch unit; meaningful only with `ex_branch_valid_i`.
- `ex_jump_i` in 1: EX holds JAL/JALR, which are unconditionally taken.
- `ex_target_i` in 32: resolved target address.
- `pc_o` out 32: fetch address.
- `fetch_valid_o` out 1: fetch request valid.
- `flush_ifid_o` out 1: clear IF/ID at the next edge.
- `flush_idex_o` out 1: clear ID/EX at the next edge.
- `misalign_o` out 1: one-cycle trap pulse.
- `badaddr_o` out 32: last misaligned target.
- `taken_cnt_o` out 16: count of accepted redirects.

## Operation
- Redirect request `redir = ex_branch_valid_i & branchtaken_i | ex_jump_i`.
  - Only evaluated in state RUN.
  - Ignored in INIT and PEND, because EX is wrong-path there.
- Destination `dest`:
  - `dest = ex_target_i` when `ex_target_i[1:0]==0`.
  - Otherwise `dest = TRAP_PC`. Additionally `misalign_o` pulses in the cycle after the request and `badaddr_o <= ex_target_i`.
- Fetch handshake `fire = fetch_valid_o & imem_ready_i`.
  - While valid, `pc_o` must not change until `fire`.
- States: INIT, RUN, PEND.
- **INIT** (entered by reset):
  - `fetch_valid_o=0`.
  - Transitions to RUN at the first edge after `rst_n` rises.
- **RUN, no redirect:**
  - `fire & ~stall_i`: `pc_o <= pc_o+4` (32-bit wrap: 0xFFFF_FFFC to 0).
  - Otherwise `pc_o` holds.
  - If `fire` occurs while `stall_i=1`, the same address is refetched; IF/ID is held by the hazard unit.
- **RUN, redir and imem_ready_i=1:**
  - `flush_ifid_o=1` and `flush_idex_o=1` this cycle.
  - `pc_o <= dest`.
  - `taken_cnt_o` increments.
  - Stay in RUN.
- **RUN, redir and imem_ready_i=0:**
  - `flush_ifid_o=1` and `flush_idex_o=1` this cycle.
  - `pend_q <= dest`.
  - `taken_cnt_o` increments.
  - Go to PEND.
- **PEND:**
  - `pc_o` holds the old address and `fetch_valid_o=1`; the outstanding fetch must complete.
  - On `fire`: `flush_ifid_o=1` (the returned instruction is wrong-path), `pc_o <= pend_q`, go to RUN.
- **Priority:** redirect beats `stall_i`; `stall_i` is ignored in a redirect cycle and in the PEND-completion cycle.
- **Flush gating:** both flush outputs are combinational, but forced to 0 in INIT and while `rst_n=0`.
- **Counter:** `taken_cnt_o` wraps from 0xFFFF to 0x0000. Misaligned redirects also count.

## Timing
- **Reset values** (asynchronous, immediate on `rst_n=0`): `pc_o=RESET_PC`, `fetch_valid_o=0`, flushes 0, `misalign_o=0`, `badaddr_o=0`, `taken_cnt_o=0`, `pend_q=0`, state INIT.
- **First fetch:** `fetch_valid_o=1` from the first edge after `rst_n` deasserts.
- **Redirect latency with ready memory:** request in cycle N gives `pc_o=dest` in cycle N+1. Wrong-path penalty is 2 instructions.
- **Redirect latency with PEND:** `pc_o=dest` in the cycle after the completing `fire`.
- **misalign_o:** asserted exactly one cycle, at N+1.
- **Reset mid-PEND:** the pending target is discarded; fetch restarts at `RESET_PC`.

## Test plan
- **Reset release, memory always ready, no redirects:**
  - `fetch_valid_o` 0 for the first cycle.
  - `pc_o` sequence 0x0, 0x4, 0x8, 0xC; flushes stay 0.
- **Taken branch:** at `pc_o`=0x10, pulse `ex_branch_valid_i=1`, `branchtaken_i=1`, `ex_target_i=0x40`.
  - Both flushes high that cycle.
  - `pc_o` goes 0x40 then 0x44.
  - `taken_cnt_o=1`.
- **Not-taken branch:** `ex_branch_valid_i=1`, `branchtaken_i=0`.
  - No flush; PC continues +4; counter unchanged.
- **Redirect with imem_ready_i=0 for 3 cycles,** `ex_jump_i=1`, target 0x200:
  - Flushes in the request cycle.
  - `pc_o` holds for 3 cycles; `flush_ifid_o` high again on the `fire` cycle.
  - `pc_o`=0x200 in the next cycle; redirect inputs during PEND are ignored.
- **Misaligned jump target 0x102:**
  - `pc_o`=0x100 (`TRAP_PC`).
  - `misalign_o` high for one cycle; `badaddr_o`=0x102.
- **Redirect coincident with `stall_i=1`:** the redirect is taken.
- **Counter wrap:** preload via 65536 redirects → `taken_cnt_o` returns to 0.
- **Asynchronous reset mid-PEND:** `pc_o`=`RESET_PC` immediately after reset asserts.

Source files
------------

// File: rtl/fetch_pc_if.sv
// Instruction-fetch handshake between the PC unit and instruction memory.
interface fetch_pc_if;
  logic [31:0] pc_o;
  logic        fetch_valid_o;
  logic        imem_ready_i;

  modport master (output pc_o, fetch_valid_o, input imem_ready_i);
  modport slave  (input pc_o, fetch_valid_o, output imem_ready_i);
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch PC register and EX-driven redirect: holds the fetch address across the
// imem handshake, squashes wrong-path work and traps misaligned targets.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        ex_branch_valid_i,
  input  logic        branchtaken_i,
  input  logic        ex_jump_i,
  input  logic [31:0] ex_target_i,
  fetch_pc_if.master  imem,
  output logic        flush_ifid_o,
  output logic        flush_idex_o,
  output logic        misalign_o,
  output logic [31:0] badaddr_o,
  output logic [15:0] taken_cnt_o
);

  typedef enum logic [1:0] {INIT, RUN, PEND} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] bad_q, bad_d;
  logic [15:0] cnt_q, cnt_d;
  logic        mis_q, mis_d;

  logic        fetch_valid, fire, redir, tgt_misal;
  logic [31:0] dest;

  assign fetch_valid = (state_q != INIT);
  assign fire        = fetch_valid & imem.imem_ready_i;
  // EX is wrong-path outside RUN, so its redirect is not even looked at.
  assign redir       = (state_q == RUN) &
                       ((ex_branch_valid_i & branchtaken_i) | ex_jump_i);
  assign tgt_misal   = (ex_target_i[1:0] != 2'b00);
  assign dest        = tgt_misal ? TRAP_PC : ex_target_i;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_d       = pend_q;
    bad_d        = bad_q;
    cnt_d        = cnt_q;
    mis_d        = 1'b0;
    flush_ifid_o = 1'b0;
    flush_idex_o = 1'b0;
    case (state_q)
      INIT: state_d = RUN;
      RUN: begin
        if (redir) begin
          // Redirect wins over stall; the outstanding fetch decides RUN vs PEND.
          flush_ifid_o = 1'b1;
          flush_idex_o = 1'b1;
          cnt_d        = cnt_q + 16'd1;
          mis_d        = tgt_misal;
          if (tgt_misal) bad_d = ex_target_i;
          if (imem.imem_ready_i) begin
            pc_d = dest;
          end else begin
            pend_d  = dest;
            state_d = PEND;
          end
        end else if (fire && !stall_i) begin
          pc_d = pc_q + 32'd4;
        end
      end
      PEND: begin
        if (fire) begin
          flush_ifid_o = 1'b1;
          pc_d         = pend_q;
          state_d      = RUN;
        end
      end
      default: state_d = INIT;
    endcase
    if (!rst_n) begin
      flush_ifid_o = 1'b0;
      flush_idex_o = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      pc_q    <= RESET_PC;
      pend_q  <= 32'd0;
      bad_q   <= 32'd0;
      cnt_q   <= 16'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      bad_q   <= bad_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end

  assign imem.pc_o          = pc_q;
  assign imem.fetch_valid_o = fetch_valid;
  assign misalign_o         = mis_q;
  assign badaddr_o          = bad_q;
  assign taken_cnt_o        = cnt_q;

endmodule
